passcode_program_controller: RTL and testbench
==============================================

Name: passcode_program_controller

Overview:
- Sequential writer that pairs with the unlock comparator: collects a new 4-digit passcode from the keypad, requires a confirming re-entry, scrambles it, and issues a single write strobe to the stored-code register.
- Sits between the keypad digit decoder and the stored-code register.
- Only writes the scrambled format {D2, D1, D0, D3}; the comparator un-scrambles that format on the unlock path.

Parameters:
- DIGIT_W, 4, bits per keypad digit. Fixed; code width = 4*DIGIT_W = 16.
- TIMEOUT_CYCLES, 1000, idle cycles allowed between accepted digits before the entry is aborted. Must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- program_req  in  1  level; starts programming when the block is idle.
- digit_valid  in  1  one-cycle strobe; digit is valid.
- digit  in  4  BCD digit, legal range 0–9.
- cancel  in  1  aborts an entry in progress.
- store_we  out  1  one-cycle write strobe to the stored-code register.
- store_data  out  16  scrambled code {D2, D1, D0, D3}.
- busy  out  1  high in any state other than IDLE.
- digit_count  out  3  digits accepted in the current pass, 0–4.
- done  out  1  one-cycle pulse, coincident with store_we.
- mismatch  out  1  one-cycle pulse; the two entries differed.
- aborted  out  1  one-cycle pulse on cancel, timeout or illegal digit.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; store_data = 16'h0000; internal shift registers, counters and timer cleared. Reset mid-entry discards all partial digits and never produces store_we.
- All outputs are registered.
- States: IDLE, ENTER1, ENTER2, CHECK, WRITE.
- IDLE:
  - program_req = 1 -> ENTER1; clear code_a, digit_count and timer.
  - digit_valid and cancel are ignored.
- ENTER1:
  - On digit_valid with digit <= 9: code_a <= {code_a[11:0], digit}; digit_count increments.
  - The first digit entered becomes D3 ([15:12]) and the last becomes D0 ([3:0]).
  - After the 4th digit: go to ENTER2 next cycle; clear digit_count, code_b and timer.
- ENTER2: same digit rules, loading code_b. After the 4th digit go to CHECK.
- CHECK (one cycle):
  - code_a == code_b -> WRITE.
  - Otherwise -> IDLE with mismatch = 1 for one cycle.
- WRITE (one cycle):
  - store_we = 1, done = 1.
  - store_data = {code_a[11:8], code_a[7:4], code_a[3:0], code_a[15:12]}.
  - Then go to IDLE. store_data holds its value after the write.
- Latency: 4th confirm digit accepted in cycle N -> CHECK in N+1 -> store_we in N+2.
- Abort conditions (ENTER1/ENTER2 only). Each returns to IDLE, pulses aborted, clears digit_count, and never writes:
  - cancel = 1. Cancel has priority over a simultaneous digit_valid, so that digit is discarded.
  - digit_valid with digit > 9.
  - Timer reaches TIMEOUT_CYCLES-1 without an accepted digit. The timer restarts on every accepted digit and on entry to ENTER1/ENTER2.
- program_req while busy has no effect; holding it high does not re-trigger until the block is back in IDLE.
- cancel in CHECK or WRITE is ignored; an in-flight write completes.
- digit_valid in CHECK or WRITE is ignored.
- At most one of done, mismatch and aborted is high in any cycle.

Decomposition:
- Shared package (lock_pkg):
  - DIGIT_W and NUM_DIGITS = 4 constants.
  - Controller state enum.
  - Scramble and unscramble helper functions, so the writer and comparator share one definition of the digit order.
- One combinational sub-module: scramble_code (16-bit in -> {in[11:8], in[7:4], in[3:0], in[15:12]}), the exact inverse of the comparator's unscrambling.

Test Plan:
- Successful program: program_req, digits 1,2,3,4, then 1,2,3,4 -> store_we high for exactly one cycle, 2 cycles after the last digit, with store_data = 16'h2341 and done coincident; busy then low.
- Mismatch: 1,2,3,4 then 1,2,3,5 -> mismatch pulse 1 cycle after the last digit; store_we never asserts; store_data keeps its previous value.
- Cancel with collision: after 2 digits, assert cancel and digit_valid(7) in the same cycle -> aborted pulse, IDLE, digit_count = 0. A following full 5,6,7,8 x2 programs 16'h6785.
- Illegal digit: digit 4'hA during ENTER2 -> aborted pulse, no write.
- Timeout (TIMEOUT_CYCLES = 16): accept 1 digit, then 16 idle cycles -> aborted by the 16th cycle. A digit arriving at cycle 14 instead restarts the timer and no abort occurs.
- Async reset: assert rst between clock edges during ENTER2 -> all outputs 0 immediately; no store_we after release.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the passcode writer and the unlock comparator.
// The scramble/unscramble pair is the single definition of the stored digit order.
package lock_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned CODE_W     = DIGIT_W * NUM_DIGITS;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTER1 = 3'd1,
        ST_ENTER2 = 3'd2,
        ST_CHECK  = 3'd3,
        ST_WRITE  = 3'd4
    } ctrl_state_e;

    // {D3,D2,D1,D0} -> {D2,D1,D0,D3}
    function automatic logic [CODE_W-1:0] scramble(input logic [CODE_W-1:0] code);
        return {code[11:8], code[7:4], code[3:0], code[15:12]};
    endfunction

    // {D2,D1,D0,D3} -> {D3,D2,D1,D0}
    function automatic logic [CODE_W-1:0] unscramble(input logic [CODE_W-1:0] code);
        return {code[3:0], code[15:12], code[11:8], code[7:4]};
    endfunction

endpackage

// File: rtl/scramble_code.sv
// Combinational digit reorder applied to a code before it is written to storage.
module scramble_code
    import lock_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [CODE_W-1:0] o_code
);

    assign o_code = scramble(i_code);

endmodule

// File: rtl/passcode_program_controller.sv
// Collects a 4-digit passcode twice, compares the entries and issues one scrambled
// write strobe to the stored-code register when they agree.
module passcode_program_controller
    import lock_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                program_req,
    input  logic                digit_valid,
    input  logic [DIGIT_W-1:0]  digit,
    input  logic                cancel,
    output logic                store_we,
    output logic [CODE_W-1:0]   store_data,
    output logic                busy,
    output logic [2:0]          digit_count,
    output logic                done,
    output logic                mismatch,
    output logic                aborted
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    ctrl_state_e        r_state;
    logic [CODE_W-1:0]  r_code_a;
    logic [CODE_W-1:0]  r_code_b;
    logic [2:0]         r_count;
    logic [TW-1:0]      r_timer;
    logic               r_store_we;
    logic [CODE_W-1:0]  r_store_data;
    logic               r_busy;
    logic               r_done;
    logic               r_mismatch;
    logic               r_aborted;

    logic               w_digit_ok;
    logic               w_accept;
    logic               w_abort;
    logic [CODE_W-1:0]  w_code_b_next;
    logic [CODE_W-1:0]  w_scrambled;

    assign w_digit_ok    = (digit <= DIGIT_W'(9));
    // Cancel wins over a coincident digit; timeout only fires on a cycle with no digit.
    assign w_accept      = digit_valid && w_digit_ok && !cancel;
    assign w_abort       = cancel || (digit_valid && !w_digit_ok)
                           || (!digit_valid && (r_timer == TIMER_LAST));
    assign w_code_b_next = {r_code_b[CODE_W-DIGIT_W-1:0], digit};

    scramble_code u_scramble (
        .i_code (r_code_a),
        .o_code (w_scrambled)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_code_a     <= '0;
            r_code_b     <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_store_we   <= 1'b0;
            r_store_data <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mismatch   <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_store_we <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_aborted  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (program_req) begin
                        r_state  <= ST_ENTER1;
                        r_busy   <= 1'b1;
                        r_code_a <= '0;
                        r_count  <= '0;
                        r_timer  <= '0;
                    end
                end
                ST_ENTER1, ST_ENTER2: begin
                    if (w_accept) begin
                        r_timer <= '0;
                        if (r_state == ST_ENTER1) begin
                            r_code_a <= {r_code_a[CODE_W-DIGIT_W-1:0], digit};
                            if (r_count == 3'd3) begin
                                r_state  <= ST_ENTER2;
                                r_count  <= '0;
                                r_code_b <= '0;
                            end else begin
                                r_count <= r_count + 3'd1;
                            end
                        end else begin
                            r_code_b <= w_code_b_next;
                            r_count  <= r_count + 3'd1;
                            if (r_count == 3'd3) begin
                                r_state    <= ST_CHECK;
                                // Flag the mismatch as soon as the last confirm digit lands.
                                r_mismatch <= (w_code_b_next != r_code_a);
                            end
                        end
                    end else if (w_abort) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_count   <= '0;
                        r_aborted <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_CHECK: begin
                    if (r_code_a == r_code_b) begin
                        r_state      <= ST_WRITE;
                        r_store_we   <= 1'b1;
                        r_done       <= 1'b1;
                        r_store_data <= w_scrambled;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign store_we    = r_store_we;
    assign store_data  = r_store_data;
    assign busy        = r_busy;
    assign digit_count = r_count;
    assign done        = r_done;
    assign mismatch    = r_mismatch;
    assign aborted     = r_aborted;

endmodule

// File: tb/tb_passcode_program_controller.sv
// Directed bench for passcode_program_controller with a short timeout.
module tb_passcode_program_controller;

    logic        clk;
    logic        rst;
    logic        program_req;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        cancel;
    logic        store_we;
    logic [15:0] store_data;
    logic        busy;
    logic [2:0]  digit_count;
    logic        done;
    logic        mismatch;
    logic        aborted;

    int n_cmp = 0;
    int n_err = 0;

    passcode_program_controller #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .program_req (program_req),
        .digit_valid (digit_valid),
        .digit       (digit),
        .cancel      (cancel),
        .store_we    (store_we),
        .store_data  (store_data),
        .busy        (busy),
        .digit_count (digit_count),
        .done        (done),
        .mismatch    (mismatch),
        .aborted     (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic start();
        program_req = 1'b1;
        tick();
        program_req = 1'b0;
    endtask

    task automatic check_pulses(input string tag, input logic we, input logic dn,
                                input logic mm, input logic ab);
        check({tag, ".store_we"}, {15'd0, store_we}, {15'd0, we});
        check({tag, ".done"},     {15'd0, done},     {15'd0, dn});
        check({tag, ".mismatch"}, {15'd0, mismatch}, {15'd0, mm});
        check({tag, ".aborted"},  {15'd0, aborted},  {15'd0, ab});
    endtask

    initial begin
        rst         = 1'b1;
        program_req = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;
        cancel      = 1'b0;
        tick();
        tick();
        check_pulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.data",  store_data, 16'h0000);
        check("reset.busy",  {15'd0, busy}, 16'd0);
        check("reset.count", {13'd0, digit_count}, 16'd0);
        rst = 1'b0;

        // Idle ignores cancel and digits
        cancel = 1'b1;
        send(4'd3);
        cancel = 1'b0;
        check("idle.busy", {15'd0, busy}, 16'd0);
        check("idle.aborted", {15'd0, aborted}, 16'd0);

        // Successful program 1234 / 1234
        start();
        check("prog.busy", {15'd0, busy}, 16'd1);
        send(4'd1); send(4'd2); send(4'd3);
        check("prog.count3", {13'd0, digit_count}, 16'd3);
        send(4'd4);
        check("prog.enter2_count", {13'd0, digit_count}, 16'd0);
        send(4'd1); send(4'd2); send(4'd3); send(4'd4);
        check_pulses("prog.check", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_pulses("prog.write", 1'b1, 1'b1, 1'b0, 1'b0);
        check("prog.data", store_data, 16'h2341);
        tick();
        check_pulses("prog.after", 1'b0, 1'b0, 1'b0, 1'b0);
        check("prog.busy_low", {15'd0, busy}, 16'd0);
        check("prog.data_hold", store_data, 16'h2341);

        // Mismatch 1234 / 1235
        start();
        send(4'd1); send(4'd2); send(4'd3); send(4'd4);
        send(4'd1); send(4'd2); send(4'd3); send(4'd5);
        check_pulses("mm.pulse", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_pulses("mm.after", 1'b0, 1'b0, 1'b0, 1'b0);
        check("mm.busy", {15'd0, busy}, 16'd0);
        tick();
        check("mm.no_we", {15'd0, store_we}, 16'd0);
        check("mm.data", store_data, 16'h2341);

        // Cancel colliding with a digit
        start();
        send(4'd9); send(4'd9);
        cancel = 1'b1;
        send(4'd7);
        cancel = 1'b0;
        check_pulses("cancel.pulse", 1'b0, 1'b0, 1'b0, 1'b1);
        check("cancel.busy", {15'd0, busy}, 16'd0);
        check("cancel.count", {13'd0, digit_count}, 16'd0);
        tick();
        check("cancel.aborted_low", {15'd0, aborted}, 16'd0);
        start();
        send(4'd5); send(4'd6); send(4'd7); send(4'd8);
        send(4'd5); send(4'd6); send(4'd7); send(4'd8);
        tick();
        check_pulses("prog2.write", 1'b1, 1'b1, 1'b0, 1'b0);
        check("prog2.data", store_data, 16'h6785);
        tick();

        // Illegal digit during the confirm pass
        start();
        send(4'd1); send(4'd2); send(4'd3); send(4'd4);
        send(4'd1);
        send(4'hA);
        check_pulses("illegal.pulse", 1'b0, 1'b0, 1'b0, 1'b1);
        check("illegal.busy", {15'd0, busy}, 16'd0);
        tick();
        tick();
        check("illegal.no_we", {15'd0, store_we}, 16'd0);
        check("illegal.data", store_data, 16'h6785);

        // Timeout after one digit
        start();
        send(4'd1);
        repeat (15) tick();
        check("to.pre_aborted", {15'd0, aborted}, 16'd0);
        check("to.pre_busy", {15'd0, busy}, 16'd1);
        tick();
        check_pulses("to.pulse", 1'b0, 1'b0, 1'b0, 1'b1);
        check("to.busy", {15'd0, busy}, 16'd0);
        tick();

        // Digit on idle cycle 14 restarts the timer
        start();
        send(4'd1);
        repeat (13) tick();
        send(4'd2);
        repeat (15) tick();
        check("restart.busy", {15'd0, busy}, 16'd1);
        check("restart.aborted", {15'd0, aborted}, 16'd0);
        check("restart.count", {13'd0, digit_count}, 16'd2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("restart.cancel", {15'd0, aborted}, 16'd1);
        tick();

        // Asynchronous reset mid-confirm
        start();
        send(4'd1); send(4'd2); send(4'd3); send(4'd4);
        send(4'd1); send(4'd2);
        check("areset.count_pre", {13'd0, digit_count}, 16'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_pulses("areset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("areset.busy", {15'd0, busy}, 16'd0);
        check("areset.count", {13'd0, digit_count}, 16'd0);
        check("areset.data", store_data, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        send(4'd3); send(4'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("areset.no_we", {15'd0, store_we}, 16'd0);
        end
        check("areset.busy_after", {15'd0, busy}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
